// File: rtl/axi_master_pkg.sv
// Shared state encoding, AXI field widths/codes and helpers for the AXI burst master.
// Pure declarations: no timing, no handshakes.
package axi_master_pkg;
    localparam int AXI_LEN_W   = 8;
    localparam int AXI_SIZE_W  = 3;
    localparam int AXI_BURST_W = 2;
    localparam int AXI_RESP_W  = 2;
    localparam int PAGE_BYTES  = 4096;

    localparam logic [AXI_BURST_W-1:0] BURST_INCR = 2'b01;

    localparam logic [AXI_RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [AXI_RESP_W-1:0] RESP_EXOKAY = 2'b01;
    localparam logic [AXI_RESP_W-1:0] RESP_SLVERR = 2'b10;
    localparam logic [AXI_RESP_W-1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_AW,
        ST_W,
        ST_B,
        ST_ERR
    } state_e;

    // Severity order matches the numeric encoding: OKAY < EXOKAY < SLVERR < DECERR.
    function automatic logic [AXI_RESP_W-1:0] resp_max(input logic [AXI_RESP_W-1:0] a,
                                                       input logic [AXI_RESP_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [AXI_SIZE_W-1:0] size_from_width(input int data_w);
        return AXI_SIZE_W'($clog2(data_w / 8));
    endfunction
endpackage

// File: rtl/axi_beat_counter.sv
// Beat counter shared by the R and W phases; clear/increment, flags the final beat (count == len).
// One cycle from inc to updated count; no handshake of its own.
module axi_beat_counter #(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [LEN_W-1:0] len,
    output logic             last
);
    // One spare bit so a max-length burst (len all-ones) cannot wrap back to zero.
    logic [LEN_W:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == {1'b0, len});
endmodule

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 burst master: one request -> AR/R or AW/W/B, worst response reported on done.
// Read latency 1 + N cycles with a zero-wait slave; write beats stall on wr_valid/WREADY, reads never stall R.
module axi_burst_master
    import axi_master_pkg::*;
#(
    parameter int              ADDR_W    = 32,
    parameter int              DATA_W    = 32,
    parameter int              ID_W      = 4,
    parameter int              LEN_W     = 4,
    parameter logic [ID_W-1:0] MASTER_ID = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [LEN_W-1:0]       req_len,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic [DATA_W/8-1:0]    wr_strb,
    output logic                   rd_valid,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   rd_last,
    output logic                   done_valid,
    output logic [AXI_RESP_W-1:0]  done_resp,
    output logic                   busy,
    output logic [ID_W-1:0]        awid,
    output logic [ADDR_W-1:0]      awaddr,
    output logic [AXI_LEN_W-1:0]   awlen,
    output logic [AXI_SIZE_W-1:0]  awsize,
    output logic [AXI_BURST_W-1:0] awburst,
    output logic                   awvalid,
    input  logic                   awready,
    output logic [DATA_W-1:0]      wdata,
    output logic [DATA_W/8-1:0]    wstrb,
    output logic                   wlast,
    output logic                   wvalid,
    input  logic                   wready,
    input  logic [ID_W-1:0]        bid,
    input  logic [AXI_RESP_W-1:0]  bresp,
    input  logic                   bvalid,
    output logic                   bready,
    output logic [ID_W-1:0]        arid,
    output logic [ADDR_W-1:0]      araddr,
    output logic [AXI_LEN_W-1:0]   arlen,
    output logic [AXI_SIZE_W-1:0]  arsize,
    output logic [AXI_BURST_W-1:0] arburst,
    output logic                   arvalid,
    input  logic                   arready,
    input  logic [ID_W-1:0]        rid,
    input  logic [DATA_W-1:0]      rdata,
    input  logic [AXI_RESP_W-1:0]  rresp,
    input  logic                   rlast,
    input  logic                   rvalid,
    output logic                   rready
);
    localparam int                    BYTES  = DATA_W / 8;
    localparam logic [AXI_SIZE_W-1:0] AXSIZE = size_from_width(DATA_W);

    state_e                  state_q, state_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [AXI_RESP_W-1:0]   resp_q, resp_d;
    logic [AXI_RESP_W-1:0]   r_resp, b_resp;
    logic [31:0]             span_end;
    logic                    crosses;
    logic                    cnt_clr, cnt_inc, cnt_last;

    axi_beat_counter #(.LEN_W(LEN_W)) u_beat_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .len  (len_q),
        .last (cnt_last)
    );

    // A burst whose exclusive end offset reaches the next 4KB page is refused locally.
    assign span_end = 32'(req_addr[11:0]) + (32'(req_len) + 32'd1) * 32'(BYTES);
    assign crosses  = (span_end >= 32'(PAGE_BYTES));

    assign arid    = MASTER_ID;
    assign araddr  = addr_q;
    assign arlen   = AXI_LEN_W'(len_q);
    assign arsize  = AXSIZE;
    assign arburst = BURST_INCR;
    assign awid    = MASTER_ID;
    assign awaddr  = addr_q;
    assign awlen   = AXI_LEN_W'(len_q);
    assign awsize  = AXSIZE;
    assign awburst = BURST_INCR;
    assign wdata   = wr_data;
    assign wstrb   = wr_strb;
    assign rd_data = rdata;
    assign busy    = (state_q != ST_IDLE);

    always_comb begin
        r_resp = resp_max(resp_q, rresp);
        // RLAST must coincide with the len-th beat; a stray ID is also a slave fault.
        if ((rid != MASTER_ID) || (rlast != cnt_last)) begin
            r_resp = resp_max(r_resp, RESP_SLVERR);
        end
        b_resp = resp_max(resp_q, bresp);
        if (bid != MASTER_ID) begin
            b_resp = resp_max(b_resp, RESP_SLVERR);
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        resp_d     = resp_q;
        req_ready  = 1'b0;
        arvalid    = 1'b0;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        wr_ready   = 1'b0;
        wlast      = 1'b0;
        bready     = 1'b0;
        rready     = 1'b0;
        rd_valid   = 1'b0;
        rd_last    = 1'b0;
        done_valid = 1'b0;
        cnt_clr    = (state_q == ST_IDLE);
        cnt_inc    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                resp_d    = RESP_OKAY;
                if (req_valid) begin
                    addr_d = req_addr;
                    len_d  = req_len;
                    if (crosses)        state_d = ST_ERR;
                    else if (req_write) state_d = ST_AW;
                    else                state_d = ST_AR;
                end
            end
            ST_AR: begin
                arvalid = 1'b1;
                if (arready) state_d = ST_R;
            end
            ST_R: begin
                rready = 1'b1;
                if (rvalid) begin
                    rd_valid = 1'b1;
                    rd_last  = rlast;
                    // Saturate at len so a missing RLAST keeps flagging until it finally arrives.
                    cnt_inc  = !cnt_last;
                    resp_d   = r_resp;
                    if (rlast) begin
                        done_valid = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
            end
            ST_AW: begin
                awvalid = 1'b1;
                if (awready) state_d = ST_W;
            end
            ST_W: begin
                wvalid   = wr_valid;
                wr_ready = wready;
                wlast    = cnt_last;
                if (wr_valid && wready) begin
                    cnt_inc = !cnt_last;
                    if (cnt_last) state_d = ST_B;
                end
            end
            ST_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    resp_d     = b_resp;
                    done_valid = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            ST_ERR: begin
                resp_d     = RESP_SLVERR;
                done_valid = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign done_resp = resp_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            resp_q  <= RESP_OKAY;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            resp_q  <= resp_d;
        end
    end
endmodule

// File: tb/tb_axi_burst_master.sv
// Bench for axi_burst_master: directed vector table, reset-in-W sequence and randomized bursts
// checked against a page/beat/response model.
module tb_axi_burst_master;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ID_W   = 4;
    localparam int LEN_W  = 4;

    logic              clk;
    logic              rst;
    logic              req_valid, req_ready, req_write;
    logic [31:0]       req_addr;
    logic [3:0]        req_len;
    logic              wr_valid, wr_ready;
    logic [31:0]       wr_data;
    logic [3:0]        wr_strb;
    logic              rd_valid, rd_last;
    logic [31:0]       rd_data;
    logic              done_valid, busy;
    logic [1:0]        done_resp;
    logic [3:0]        awid, arid, bid, rid;
    logic [31:0]       awaddr, araddr, wdata, rdata;
    logic [7:0]        awlen, arlen;
    logic [2:0]        awsize, arsize;
    logic [1:0]        awburst, arburst, bresp, rresp;
    logic              awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic              arvalid, arready, rlast, rvalid, rready;
    logic [3:0]        wstrb;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int o_done, o_resp, o_beats, o_avalid, o_proto, o_lat;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  len;
        int          a_dly;
        int          gap;
        logic [1:0]  resp;
        int          strb;
        int          nlast;
        logic        bad_id;
        int          e_beats;
        int          e_resp;
        int          e_avalid;
        int          e_lat;
    } vec_t;

    vec_t vecs[11];

    axi_burst_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .LEN_W(LEN_W), .MASTER_ID(4'd0)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
        .done_valid(done_valid), .done_resp(done_resp), .busy(busy),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        #1;
        if (done_valid === 1'b1) done_cnt++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        req_valid = 0; req_write = 0; req_addr = 0; req_len = 0;
        wr_valid = 0; wr_data = 0; wr_strb = 0;
        awready = 0; wready = 0; bvalid = 0; bid = 0; bresp = 0;
        arready = 0; rvalid = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0;
    endtask

    // Reference: 4KB page rule, beats delivered by the slave, worst response plus local faults.
    task automatic model(input vec_t v, output int beats, output int resp, output int avalid);
        int span;
        span = int'(v.addr[11:0]) + (int'(v.len) + 1) * 4;
        if (span >= 4096) begin
            beats = 0; resp = 2; avalid = 0;
        end else begin
            avalid = 1;
            resp   = int'(v.resp);
            beats  = int'(v.len) + 1;
            if (!v.wr && v.nlast != 0) beats = v.nlast;
            if (beats != int'(v.len) + 1 || v.bad_id) resp = (resp > 2) ? resp : 2;
        end
    endtask

    // Acts as requester and AXI slave for one transaction, collecting observations.
    task automatic run_txn(input vec_t v);
        int cyc, a_wait, beat, nl;
        logic a_done, x_fin, fin;
        nl = (v.nlast == 0) ? int'(v.len) + 1 : v.nlast;
        o_done = 0; o_resp = -1; o_beats = 0; o_avalid = 0; o_proto = 0; o_lat = -1;
        @(negedge clk);
        req_valid = 1; req_write = v.wr; req_addr = v.addr; req_len = v.len;
        #1;
        if (req_ready !== 1'b1) o_proto++;
        @(negedge clk);
        req_valid = 0;
        cyc = 0; a_wait = 0; beat = 0; a_done = 0; x_fin = 0; fin = 0;
        while (!fin && cyc < 400) begin
            arready  = !v.wr && !a_done && (a_wait >= v.a_dly);
            awready  = v.wr && !a_done && (a_wait >= v.a_dly);
            rvalid   = !v.wr && a_done && !x_fin && ($urandom_range(99) >= v.gap);
            rlast    = rvalid && (beat + 1 == nl);
            rdata    = $urandom; rresp = v.resp; rid = v.bad_id ? 4'd1 : 4'd0;
            wr_valid = v.wr && !x_fin && ($urandom_range(99) >= v.gap);
            wr_data  = $urandom;
            wr_strb  = (v.strb < 0) ? 4'($urandom) : 4'(v.strb);
            wready   = v.wr && a_done && !x_fin && ($urandom_range(99) >= v.gap);
            bvalid   = v.wr && x_fin; bresp = v.resp; bid = v.bad_id ? 4'd1 : 4'd0;
            #1;
            if (busy !== 1'b1) o_proto++;
            if (arvalid || awvalid) begin
                o_avalid = 1;
                a_wait++;
                if (a_done || (arvalid && v.wr) || (awvalid && !v.wr)) o_proto++;
                if (v.wr && (awaddr !== v.addr || awlen !== 8'(v.len) || awsize !== 3'd2 ||
                             awburst !== 2'b01 || awid !== 4'd0)) o_proto++;
                if (!v.wr && (araddr !== v.addr || arlen !== 8'(v.len) || arsize !== 3'd2 ||
                              arburst !== 2'b01 || arid !== 4'd0)) o_proto++;
            end
            if (rready !== (!v.wr && a_done && !x_fin)) o_proto++;
            if (rd_valid !== (rvalid && rready)) o_proto++;
            if (wvalid !== (a_done && !x_fin && wr_valid)) o_proto++;
            if (wr_ready !== wready) o_proto++;
            if (bready !== bvalid) o_proto++;
            if (rvalid && rready) begin
                if (rd_data !== rdata || rd_last !== rlast) o_proto++;
                beat++;
                if (rlast) x_fin = 1;
            end
            if (wvalid && wready) begin
                if (wdata !== wr_data || wstrb !== wr_strb || wlast !== (beat == int'(v.len))) o_proto++;
                beat++;
                if (beat == int'(v.len) + 1) x_fin = 1;
            end
            if (done_valid === 1'b1) begin
                fin = 1; o_done = 1; o_resp = int'(done_resp); o_lat = cyc;
            end
            if ((arvalid && arready) || (awvalid && awready)) a_done = 1;
            @(negedge clk);
            cyc++;
        end
        o_beats = beat;
        idle_inputs();
        #1;
        if (done_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) o_proto++;
        if (!fin) begin
            rst = 1;
            @(negedge clk);
            rst = 0;
        end
    endtask

    task automatic apply(input string nm, input vec_t v);
        run_txn(v);
        chk({nm, " done"}, o_done, 1);
        chk({nm, " resp"}, o_resp, v.e_resp);
        chk({nm, " beats"}, o_beats, v.e_beats);
        chk({nm, " addr_phase"}, o_avalid, v.e_avalid);
        chk({nm, " protocol"}, o_proto, 0);
        if (v.e_lat >= 0) chk({nm, " latency"}, o_lat, v.e_lat);
    endtask

    initial begin
        vec_t v;
        int   d0;
        //            wr    addr          len  dly gap resp  strb nlast bad   beats resp av lat
        vecs[0]  = '{1'b0, 32'h0000_0100, 4'd3,  0,  0, 2'd0, -1,  0, 1'b0,   4, 0, 1,  4};
        vecs[1]  = '{1'b1, 32'h0000_0200, 4'd0,  3,  0, 2'd0,  3,  0, 1'b0,   1, 0, 1,  5};
        vecs[2]  = '{1'b0, 32'h0000_0FC0, 4'd15, 0,  0, 2'd0, -1,  0, 1'b0,   0, 2, 0,  0};
        vecs[3]  = '{1'b1, 32'h0000_0300, 4'd3,  1, 40, 2'd3, -1,  0, 1'b0,   4, 3, 1, -1};
        vecs[4]  = '{1'b0, 32'h0000_0400, 4'd3,  0,  0, 2'd0, -1,  2, 1'b0,   2, 2, 1,  2};
        vecs[5]  = '{1'b0, 32'h0000_0500, 4'd2,  0,  0, 2'd0, -1,  5, 1'b0,   5, 2, 1,  5};
        vecs[6]  = '{1'b0, 32'h0000_0600, 4'd1,  2,  0, 2'd1, -1,  0, 1'b1,   2, 2, 1,  4};
        vecs[7]  = '{1'b1, 32'h0000_0700, 4'd1,  0,  0, 2'd0, -1,  0, 1'b1,   2, 2, 1,  3};
        vecs[8]  = '{1'b1, 32'h0000_1FF8, 4'd3,  0,  0, 2'd0, -1,  0, 1'b0,   0, 2, 0,  0};
        vecs[9]  = '{1'b0, 32'h0000_2000, 4'd15, 1, 30, 2'd1, -1,  0, 1'b0,  16, 1, 1, -1};
        vecs[10] = '{1'b0, 32'h0000_3F00, 4'd15, 0,  0, 2'd0, -1,  0, 1'b0,  16, 0, 1, 16};

        idle_inputs();
        rst = 1;
        repeat (3) @(negedge clk);
        rst = 0;
        #1;
        chk("reset valids", {23'd0, arvalid, awvalid, wvalid, wr_ready, bready, rready,
                             rd_valid, done_valid, busy}, 0);
        chk("reset req_ready", {31'd0, req_ready}, 1);

        for (int i = 0; i < 11; i++) apply($sformatf("vec%0d", i), vecs[i]);

        // Reset while two beats into a four-beat write.
        d0 = done_cnt;
        @(negedge clk);
        req_valid = 1; req_write = 1; req_addr = 32'h800; req_len = 4'd3;
        @(negedge clk);
        req_valid = 0; awready = 1;
        @(negedge clk);
        awready = 0; wr_valid = 1; wready = 1; wr_data = 32'hA5A5_0001; wr_strb = 4'hF;
        @(negedge clk);
        wr_data = 32'hA5A5_0002;
        @(negedge clk);
        rst = 1;
        #1;
        chk("rst pre wvalid", {31'd0, wvalid}, 1);
        @(posedge clk);
        #1;
        chk("rst post valids", {23'd0, arvalid, awvalid, wvalid, wr_ready, bready, rready,
                                rd_valid, done_valid, busy}, 0);
        @(negedge clk);
        rst = 0;
        idle_inputs();
        #2;
        chk("rst no done", done_cnt, d0);

        for (int i = 0; i < 40; i++) begin
            v.wr     = 1'($urandom);
            v.len    = 4'($urandom);
            v.addr   = ($urandom & 32'hFFFF_F000) |
                       (($urandom_range(1) == 1) ? ($urandom_range(1023) << 2)
                                                 : (32'hFC0 + ($urandom_range(15) << 2)));
            v.a_dly  = $urandom_range(3);
            v.gap    = $urandom_range(50);
            v.resp   = 2'($urandom);
            v.strb   = -1;
            v.nlast  = ($urandom_range(4) == 0) ? $urandom_range(int'(v.len) + 3, 1) : 0;
            v.bad_id = ($urandom_range(9) == 0);
            v.e_lat  = -1;
            model(v, v.e_beats, v.e_resp, v.e_avalid);
            apply($sformatf("rnd%0d", i), v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
